// File: rtl/branch_ctrl_if.sv
// branch_ctrl_if: bundle of the ID-stage, hazard, comparator and redirect
// signals exchanged between the pipeline and the branch controller.
interface branch_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             id_valid;
    logic             id_is_branch;
    logic [2:0]       id_funct3;
    logic [31:0]      id_pc;
    logic [31:0]      id_imm;
    logic             rs1_ready;
    logic             rs2_ready;
    logic             ex_flush;
    logic [2:0]       cmp_ctrl;
    logic             cmp_c;
    logic             stall_if_id;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             flush_if;
    logic             illegal_br;
    logic [CNT_W-1:0] cnt_branch;
    logic [CNT_W-1:0] cnt_taken;

    // Pipeline / comparator side
    modport master (
        output id_valid, id_is_branch, id_funct3, id_pc, id_imm,
               rs1_ready, rs2_ready, ex_flush, cmp_c,
        input  cmp_ctrl, stall_if_id, redirect_valid, redirect_pc,
               flush_if, illegal_br, cnt_branch, cnt_taken
    );

    // Branch controller side
    modport slave (
        input  id_valid, id_is_branch, id_funct3, id_pc, id_imm,
               rs1_ready, rs2_ready, ex_flush, cmp_c,
        output cmp_ctrl, stall_if_id, redirect_valid, redirect_pc,
               flush_if, illegal_br, cnt_branch, cnt_taken
    );
endinterface

// File: rtl/branch_ctrl.sv
// branch_ctrl: ID-stage branch resolution controller. Accepts a B-type
// instruction, stalls IF/ID until both operands reach the shared comparator,
// drives the comparator control code for one RESOLVE cycle and issues a
// one-cycle PC redirect plus IF flush when the branch is taken.
module branch_ctrl #(
    parameter int CNT_W = 32
) (
    input logic          clk,
    input logic          rst,
    branch_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        WAIT    = 2'b01,
        RESOLVE = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    state_t           state_next;
    logic [2:0]       ctrl_q;
    logic             legal_q;
    logic [31:0]      pc_q;
    logic [31:0]      imm_q;
    logic [CNT_W-1:0] cnt_branch_q;
    logic [CNT_W-1:0] cnt_taken_q;
    logic             accept;
    logic             both_ready;
    logic             resolve_ok;

    // Comparator control code for each branch funct3; 010/011 select "always 0"
    function automatic logic [2:0] map_ctrl(input logic [2:0] f3);
        logic [2:0] code;
        case (f3)
            3'b000:  code = 3'b001;
            3'b001:  code = 3'b010;
            3'b100:  code = 3'b011;
            3'b101:  code = 3'b101;
            3'b110:  code = 3'b100;
            3'b111:  code = 3'b110;
            default: code = 3'b000;
        endcase
        return code;
    endfunction

    assign both_ready = bus.rs1_ready & bus.rs2_ready;
    assign accept     = (state == IDLE) & bus.id_valid & bus.id_is_branch & ~bus.ex_flush;
    assign resolve_ok = (state == RESOLVE) & ~bus.ex_flush & ~rst;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic; an EX flush squashes whatever branch is in flight
    always_comb begin
        state_next = state;
        if (bus.ex_flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_next = both_ready ? RESOLVE : WAIT;
                WAIT:    if (both_ready) state_next = RESOLVE;
                RESOLVE: state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Outputs; reset and flush silence every pipeline-control pulse
    always_comb begin
        bus.stall_if_id    = ~rst & (accept | ((state == WAIT) & ~bus.ex_flush));
        bus.cmp_ctrl       = (state == RESOLVE) ? ctrl_q : 3'b000;
        bus.redirect_valid = resolve_ok & legal_q & bus.cmp_c;
        bus.flush_if       = resolve_ok & legal_q & bus.cmp_c;
        bus.redirect_pc    = 32'h0;
        if (resolve_ok & legal_q & bus.cmp_c) bus.redirect_pc = pc_q + imm_q;
        bus.illegal_br     = resolve_ok & ~legal_q;
    end

    // Capture the branch fields at accept so they stay stable while ID stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q  <= 3'b000;
            legal_q <= 1'b0;
            pc_q    <= 32'h0;
            imm_q   <= 32'h0;
        end else if (accept) begin
            ctrl_q  <= map_ctrl(bus.id_funct3);
            legal_q <= (bus.id_funct3[2:1] != 2'b01);
            pc_q    <= bus.id_pc;
            imm_q   <= bus.id_imm;
        end
    end

    // Statistics counters, bumped only by a legal branch that really resolves
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_branch_q <= '0;
            cnt_taken_q  <= '0;
        end else if (resolve_ok & legal_q) begin
            cnt_branch_q <= cnt_branch_q + CNT_ONE;
            if (bus.cmp_c) cnt_taken_q <= cnt_taken_q + CNT_ONE;
        end
    end

    assign bus.cnt_branch = cnt_branch_q;
    assign bus.cnt_taken  = cnt_taken_q;
endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: self-checking bench for branch_ctrl. A 32-bit-counter
// instance and a 4-bit-counter instance see the same stimulus; both talk to a
// behavioural model of the cmp_32 comparator.
module tb_branch_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] model_branch;
    logic [31:0] model_taken;

    int          s_stalls;
    logic [2:0]  s_ctrl;
    logic        s_rv;
    logic        s_fl;
    logic        s_ill;
    logic [31:0] s_pc;

    branch_ctrl_if #(.CNT_W(32)) bus ();
    branch_ctrl_if #(.CNT_W(4))  bus4 ();

    branch_ctrl #(.CNT_W(32)) dut  (.clk(clk), .rst(rst), .bus(bus));
    branch_ctrl #(.CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

    always #5 clk = ~clk;

    // Comparator environment model: code -> relation on the operands
    function automatic logic cmp_model(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
        case (code)
            3'b001:  return a == b;
            3'b010:  return a != b;
            3'b011:  return $signed(a) < $signed(b);
            3'b100:  return a < b;
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    assign bus.cmp_c         = cmp_model(bus.cmp_ctrl, op_a, op_b);
    assign bus4.cmp_c        = cmp_model(bus4.cmp_ctrl, op_a, op_b);
    assign bus4.id_valid     = bus.id_valid;
    assign bus4.id_is_branch = bus.id_is_branch;
    assign bus4.id_funct3    = bus.id_funct3;
    assign bus4.id_pc        = bus.id_pc;
    assign bus4.id_imm       = bus.id_imm;
    assign bus4.rs1_ready    = bus.rs1_ready;
    assign bus4.rs2_ready    = bus.rs2_ready;
    assign bus4.ex_flush     = bus.ex_flush;

    // Reference: RV32I branch semantics straight from funct3
    function automatic logic ref_legal(input logic [2:0] f3);
        return !(f3 == 3'b010 || f3 == 3'b011);
    endfunction

    function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) < $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] ref_ctrl(input logic [2:0] f3);
        logic [2:0] table_q [8];
        table_q = '{3'b001, 3'b010, 3'b000, 3'b000, 3'b011, 3'b101, 3'b100, 3'b110};
        return table_q[f3];
    endfunction

    // One bubble cycle with no instruction in ID
    task automatic idle_cycle();
        @(negedge clk);
        bus.id_valid = 1'b0; bus.id_is_branch = 1'b0; bus.ex_flush = 1'b0;
        bus.rs1_ready = 1'b1; bus.rs2_ready = 1'b1;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; bus.id_valid = 1'b0; bus.id_is_branch = 1'b0; bus.ex_flush = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_branch = 32'h0; model_taken = 32'h0;
        #1;
    endtask

    // Present one branch, hold one operand not-ready for nwait cycles, record the resolve cycle
    task automatic drive_branch(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                                input logic [31:0] a, input logic [31:0] b, input int nwait, input logic low_rs2);
        s_stalls = 0; s_ctrl = 3'bxxx; s_rv = 1'bx; s_fl = 1'bx; s_ill = 1'bx; s_pc = 32'hx;
        for (int cyc = 0; cyc < nwait + 8; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                bus.id_valid = 1'b1; bus.id_is_branch = 1'b1; bus.id_funct3 = f3;
                bus.id_pc = pc; bus.id_imm = imm; bus.ex_flush = 1'b0;
                op_a = a; op_b = b;
            end
            bus.rs1_ready = low_rs2 ? 1'b1 : (cyc >= nwait);
            bus.rs2_ready = low_rs2 ? (cyc >= nwait) : 1'b1;
            #1;
            if (bus.stall_if_id === 1'b1) begin
                s_stalls++;
            end else begin
                s_ctrl = bus.cmp_ctrl; s_rv = bus.redirect_valid; s_fl = bus.flush_if;
                s_ill = bus.illegal_br; s_pc = bus.redirect_pc;
                break;
            end
        end
        if (ref_legal(f3)) begin
            model_branch = model_branch + 1;
            if (ref_taken(f3, a, b)) model_taken = model_taken + 1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.id_valid = 1'b1; bus.id_is_branch = 1'b1; bus.id_funct3 = 3'b000;
        bus.id_pc = 32'h40; bus.id_imm = 32'h8; bus.rs1_ready = 1'b1; bus.rs2_ready = 1'b1;
        bus.ex_flush = 1'b0; op_a = 32'h0; op_b = 32'h0;
        @(negedge clk); @(negedge clk); #1;
        checks++; if (bus.stall_if_id !== 1'b0) begin errors++; $display("[TB] FAIL rst_stall got %b want 0", bus.stall_if_id); end
        checks++; if (bus.redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_redirect got %b want 0", bus.redirect_valid); end
        checks++; if (bus.flush_if !== 1'b0) begin errors++; $display("[TB] FAIL rst_flush got %b want 0", bus.flush_if); end
        checks++; if (bus.cmp_ctrl !== 3'b000) begin errors++; $display("[TB] FAIL rst_cmp_ctrl got %b want 000", bus.cmp_ctrl); end
        checks++; if (bus.cnt_branch !== 32'h0) begin errors++; $display("[TB] FAIL rst_cnt_branch got %0d want 0", bus.cnt_branch); end
        checks++; if (bus4.cnt_taken !== 4'h0) begin errors++; $display("[TB] FAIL rst_cnt_taken4 got %0d want 0", bus4.cnt_taken); end
        bus.id_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0; model_branch = 32'h0; model_taken = 32'h0;
        #1;
        checks++; if (bus.stall_if_id !== 1'b0) begin errors++; $display("[TB] FAIL post_rst_stall got %b want 0", bus.stall_if_id); end
        checks++; if (bus.illegal_br !== 1'b0) begin errors++; $display("[TB] FAIL post_rst_illegal got %b want 0", bus.illegal_br); end
    endtask

    task automatic test_non_branch();
        @(negedge clk);
        bus.id_valid = 1'b1; bus.id_is_branch = 1'b0; bus.id_funct3 = 3'b000;
        op_a = 32'h7; op_b = 32'h7;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.stall_if_id !== 1'b0 || bus.redirect_valid !== 1'b0 || bus.cmp_ctrl !== 3'b000)
                begin errors++; $display("[TB] FAIL non_branch cyc %0d got stall=%b rv=%b ctrl=%b want 0 0 000", i, bus.stall_if_id, bus.redirect_valid, bus.cmp_ctrl); end
            @(negedge clk);
        end
        bus.id_valid = 1'b0;
        #1;
        checks++; if (bus.cnt_branch !== model_branch) begin errors++; $display("[TB] FAIL non_branch_cnt got %0d want %0d", bus.cnt_branch, model_branch); end
    endtask

    task automatic test_beq_taken();
        drive_branch(3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 0, 1'b0);
        checks++; if (s_stalls !== 1) begin errors++; $display("[TB] FAIL beq_stalls got %0d want 1", s_stalls); end
        checks++; if (s_ctrl !== 3'b001) begin errors++; $display("[TB] FAIL beq_ctrl got %b want 001", s_ctrl); end
        checks++; if (s_rv !== 1'b1 || s_fl !== 1'b1) begin errors++; $display("[TB] FAIL beq_redirect got rv=%b fl=%b want 1 1", s_rv, s_fl); end
        checks++; if (s_pc !== 32'h120) begin errors++; $display("[TB] FAIL beq_pc got %h want 00000120", s_pc); end
        idle_cycle();
        checks++; if (bus.cnt_branch !== 32'd1) begin errors++; $display("[TB] FAIL beq_cnt_branch got %0d want 1", bus.cnt_branch); end
        checks++; if (bus.cnt_taken !== 32'd1) begin errors++; $display("[TB] FAIL beq_cnt_taken got %0d want 1", bus.cnt_taken); end
        checks++; if (bus.redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL beq_redirect_one_cycle got %b want 0", bus.redirect_valid); end
    endtask

    task automatic test_blt_vs_bltu();
        do_reset();
        drive_branch(3'b100, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'h1, 0, 1'b0);
        checks++; if (s_ctrl !== 3'b011) begin errors++; $display("[TB] FAIL blt_ctrl got %b want 011", s_ctrl); end
        checks++; if (s_rv !== 1'b1 || s_pc !== 32'h240) begin errors++; $display("[TB] FAIL blt_taken got rv=%b pc=%h want 1 00000240", s_rv, s_pc); end
        idle_cycle();
        drive_branch(3'b110, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'h1, 0, 1'b0);
        checks++; if (s_ctrl !== 3'b100) begin errors++; $display("[TB] FAIL bltu_ctrl got %b want 100", s_ctrl); end
        checks++; if (s_rv !== 1'b0 || s_fl !== 1'b0 || s_pc !== 32'h0) begin errors++; $display("[TB] FAIL bltu_not_taken got rv=%b fl=%b pc=%h want 0 0 0", s_rv, s_fl, s_pc); end
        idle_cycle();
        checks++; if (bus.cnt_branch !== 32'd2 || bus.cnt_taken !== 32'd1) begin errors++; $display("[TB] FAIL blt_counts got %0d/%0d want 2/1", bus.cnt_branch, bus.cnt_taken); end
    endtask

    task automatic test_load_use_wait();
        drive_branch(3'b001, 32'h1000, 32'hFFFF_FFF0, 32'd1, 32'd2, 3, 1'b0);
        checks++; if (s_stalls !== 4) begin errors++; $display("[TB] FAIL wait_stalls got %0d want 4", s_stalls); end
        checks++; if (s_ctrl !== 3'b010) begin errors++; $display("[TB] FAIL wait_ctrl got %b want 010", s_ctrl); end
        checks++; if (s_rv !== 1'b1 || s_pc !== 32'h0000_0FF0) begin errors++; $display("[TB] FAIL wait_redirect got rv=%b pc=%h want 1 00000ff0", s_rv, s_pc); end
        idle_cycle();
        checks++; if (bus.cnt_taken !== model_taken) begin errors++; $display("[TB] FAIL wait_cnt_taken got %0d want %0d", bus.cnt_taken, model_taken); end
    endtask

    task automatic test_illegal();
        logic [31:0] br0;
        br0 = model_branch;
        for (int k = 0; k < 2; k++) begin
            drive_branch(k == 0 ? 3'b010 : 3'b011, 32'h500, 32'h10, 32'd9, 32'd9, 0, 1'b0);
            checks++; if (s_ctrl !== 3'b000) begin errors++; $display("[TB] FAIL illegal%0d_ctrl got %b want 000", k, s_ctrl); end
            checks++; if (s_ill !== 1'b1) begin errors++; $display("[TB] FAIL illegal%0d_pulse got %b want 1", k, s_ill); end
            checks++; if (s_rv !== 1'b0 || s_fl !== 1'b0) begin errors++; $display("[TB] FAIL illegal%0d_redirect got rv=%b fl=%b want 0 0", k, s_rv, s_fl); end
            idle_cycle();
            checks++; if (bus.illegal_br !== 1'b0) begin errors++; $display("[TB] FAIL illegal%0d_one_cycle got %b want 0", k, bus.illegal_br); end
        end
        checks++; if (bus.cnt_branch !== br0) begin errors++; $display("[TB] FAIL illegal_cnt got %0d want %0d", bus.cnt_branch, br0); end
    endtask

    task automatic test_ex_flush();
        logic [31:0] br0;
        logic [31:0] tk0;
        br0 = model_branch; tk0 = model_taken;
        // flush while waiting on an operand
        @(negedge clk);
        bus.id_valid = 1'b1; bus.id_is_branch = 1'b1; bus.id_funct3 = 3'b000;
        bus.id_pc = 32'h600; bus.id_imm = 32'h4; op_a = 32'd3; op_b = 32'd3;
        bus.rs1_ready = 1'b0; bus.rs2_ready = 1'b1; #1;
        checks++; if (bus.stall_if_id !== 1'b1) begin errors++; $display("[TB] FAIL flush_accept_stall got %b want 1", bus.stall_if_id); end
        @(negedge clk); bus.ex_flush = 1'b1; #1;
        checks++; if (bus.stall_if_id !== 1'b0) begin errors++; $display("[TB] FAIL flush_wait_stall got %b want 0", bus.stall_if_id); end
        @(negedge clk); bus.ex_flush = 1'b0; bus.id_valid = 1'b0; bus.id_is_branch = 1'b0; #1;
        checks++; if (bus.stall_if_id !== 1'b0 || bus.redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_idle got stall=%b rv=%b want 0 0", bus.stall_if_id, bus.redirect_valid); end
        bus.rs1_ready = 1'b1;
        @(negedge clk); #1;
        checks++; if (bus.redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_late_redirect got %b want 0", bus.redirect_valid); end
        // flush during a taken RESOLVE
        @(negedge clk);
        bus.id_valid = 1'b1; bus.id_is_branch = 1'b1; bus.id_funct3 = 3'b000; #1;
        @(negedge clk); bus.ex_flush = 1'b1; #1;
        checks++; if (bus.redirect_valid !== 1'b0 || bus.flush_if !== 1'b0) begin errors++; $display("[TB] FAIL flush_resolve got rv=%b fl=%b want 0 0", bus.redirect_valid, bus.flush_if); end
        // flush in IDLE blocks the accept
        @(negedge clk); #1;
        checks++; if (bus.stall_if_id !== 1'b0) begin errors++; $display("[TB] FAIL flush_idle_accept got %b want 0", bus.stall_if_id); end
        @(negedge clk); bus.ex_flush = 1'b0; bus.id_valid = 1'b0; #1;
        checks++; if (bus.redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_idle_redirect got %b want 0", bus.redirect_valid); end
        idle_cycle();
        checks++; if (bus.cnt_branch !== br0 || bus.cnt_taken !== tk0) begin errors++; $display("[TB] FAIL flush_cnt got %0d/%0d want %0d/%0d", bus.cnt_branch, bus.cnt_taken, br0, tk0); end
    endtask

    task automatic test_reset_mid_resolve();
        @(negedge clk);
        bus.id_valid = 1'b1; bus.id_is_branch = 1'b1; bus.id_funct3 = 3'b101;
        bus.id_pc = 32'h700; bus.id_imm = 32'h8; op_a = 32'd5; op_b = 32'd3;
        bus.rs1_ready = 1'b1; bus.rs2_ready = 1'b1; #1;
        checks++; if (bus.stall_if_id !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_stall got %b want 1", bus.stall_if_id); end
        @(negedge clk); rst = 1'b1; #1;
        checks++; if (bus.redirect_valid !== 1'b0 || bus.flush_if !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_redirect got rv=%b fl=%b want 0 0", bus.redirect_valid, bus.flush_if); end
        @(negedge clk); rst = 1'b0; bus.id_valid = 1'b0; model_branch = 32'h0; model_taken = 32'h0; #1;
        checks++; if (bus.cnt_branch !== 32'h0 || bus.cnt_taken !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_cnt got %0d/%0d want 0/0", bus.cnt_branch, bus.cnt_taken); end
        checks++; if (bus.redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_after got %b want 0", bus.redirect_valid); end
    endtask

    task automatic test_back_to_back();
        drive_branch(3'b000, 32'h800, 32'h10, 32'd1, 32'd2, 0, 1'b0);
        checks++; if (s_rv !== 1'b0) begin errors++; $display("[TB] FAIL b2b_first got rv=%b want 0", s_rv); end
        drive_branch(3'b001, 32'h804, 32'h20, 32'd1, 32'd2, 0, 1'b0);
        checks++; if (s_stalls !== 1) begin errors++; $display("[TB] FAIL b2b_second_stalls got %0d want 1", s_stalls); end
        checks++; if (s_rv !== 1'b1 || s_pc !== 32'h824) begin errors++; $display("[TB] FAIL b2b_second got rv=%b pc=%h want 1 00000824", s_rv, s_pc); end
        idle_cycle();
        checks++; if (bus.stall_if_id !== 1'b0) begin errors++; $display("[TB] FAIL b2b_bubble_stall got %b want 0", bus.stall_if_id); end
        drive_branch(3'b111, 32'h824, 32'h8, 32'd2, 32'd2, 1, 1'b1);
        checks++; if (s_stalls !== 2 || s_rv !== 1'b1 || s_pc !== 32'h82C) begin errors++; $display("[TB] FAIL b2b_third got st=%0d rv=%b pc=%h want 2 1 0000082c", s_stalls, s_rv, s_pc); end
        idle_cycle();
        checks++; if (bus.cnt_branch !== model_branch || bus.cnt_taken !== model_taken) begin errors++; $display("[TB] FAIL b2b_cnt got %0d/%0d want %0d/%0d", bus.cnt_branch, bus.cnt_taken, model_branch, model_taken); end
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a, b, pc, imm;
        int          nw;
        logic        tk;
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a = $urandom; pc = $urandom; imm = $urandom;
            b = ($urandom_range(0, 2) == 0) ? a : $urandom;
            nw = $urandom_range(0, 3);
            tk = ref_legal(f3) && ref_taken(f3, a, b);
            drive_branch(f3, pc, imm, a, b, nw, 1'($urandom_range(0, 1)));
            checks++; if (s_stalls !== nw + 1) begin errors++; $display("[TB] FAIL rnd%0d_stalls got %0d want %0d", i, s_stalls, nw + 1); end
            checks++; if (s_ctrl !== ref_ctrl(f3)) begin errors++; $display("[TB] FAIL rnd%0d_ctrl got %b want %b", i, s_ctrl, ref_ctrl(f3)); end
            checks++; if (s_rv !== tk || s_fl !== tk) begin errors++; $display("[TB] FAIL rnd%0d_taken got rv=%b fl=%b want %b", i, s_rv, s_fl, tk); end
            checks++; if (s_pc !== (tk ? pc + imm : 32'h0)) begin errors++; $display("[TB] FAIL rnd%0d_pc got %h want %h", i, s_pc, tk ? pc + imm : 32'h0); end
            checks++; if (s_ill !== !ref_legal(f3)) begin errors++; $display("[TB] FAIL rnd%0d_illegal got %b want %b", i, s_ill, !ref_legal(f3)); end
            if (tk || $urandom_range(0, 1) == 1) idle_cycle();
        end
        idle_cycle();
        checks++; if (bus.cnt_branch !== model_branch || bus.cnt_taken !== model_taken) begin errors++; $display("[TB] FAIL rnd_cnt got %0d/%0d want %0d/%0d", bus.cnt_branch, bus.cnt_taken, model_branch, model_taken); end
        checks++; if (bus4.cnt_branch !== model_branch[3:0] || bus4.cnt_taken !== model_taken[3:0]) begin errors++; $display("[TB] FAIL rnd_cnt4 got %0d/%0d want %0d/%0d", bus4.cnt_branch, bus4.cnt_taken, model_branch[3:0], model_taken[3:0]); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive_branch(3'b000, 32'h40 * i, 32'h4, 32'd7, 32'd7, 0, 1'b0);
            idle_cycle();
        end
        checks++; if (bus4.cnt_branch !== 4'd1) begin errors++; $display("[TB] FAIL wrap_cnt_branch4 got %0d want 1", bus4.cnt_branch); end
        checks++; if (bus4.cnt_taken !== 4'd1) begin errors++; $display("[TB] FAIL wrap_cnt_taken4 got %0d want 1", bus4.cnt_taken); end
        checks++; if (bus.cnt_branch !== model_branch || bus.cnt_taken !== model_taken) begin errors++; $display("[TB] FAIL wrap_cnt32 got %0d/%0d want %0d/%0d", bus.cnt_branch, bus.cnt_taken, model_branch, model_taken); end
    endtask

    initial begin
        test_reset();
        test_non_branch();
        test_beq_taken();
        test_blt_vs_bltu();
        test_load_use_wait();
        test_illegal();
        test_ex_flush();
        test_reset_mid_resolve();
        test_back_to_back();
        test_random();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

ID-stage branch resolution controller for the pipelined RV32I core. It sequences the shared 32-bit branch comparator (`cmp_32`). It accepts B-type instructions, stalls IF/ID until operands are forwarded-ready, then drives the comparator control code and samples its result. On a taken branch it issues a one-cycle PC redirect and IF flush. It also keeps branch/taken statistics counters.

## Interface
- `CNT_W`, default 32: width of the statistics counters.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: synchronous reset, active-high.
- `id_valid` input 1: ID stage holds a valid instruction.
- `id_is_branch` input 1: the ID instruction is B-type (opcode 1100011).
- `id_funct3` input 3: branch funct3.
- `id_pc` input 32: PC of the ID instruction.
- `id_imm` input 32: sign-extended B-immediate.
- `rs1_ready`, `rs2_ready` input 1 each: hazard unit reports the operand is available at the comparator inputs this cycle.
- `ex_flush` input 1: a younger-killing event from EX (jal/jalr/exception) that squashes the ID instruction.
- `cmp_ctrl` output 3: control code to the comparator.
- `cmp_c` input 1: comparator result (combinational from `cmp_ctrl` and operands).
- `stall_if_id` output 1: hold the PC and IF/ID register.
- `redirect_valid` output 1: load `redirect_pc` into the PC this edge.
- `redirect_pc` output 32: branch target.
- `flush_if` output 1: turn the IF/ID register into a bubble at this edge.
- `illegal_br` output 1: one-cycle pulse for funct3 010/011.
- `cnt_branch` output CNT_W: number of resolved legal branches.
- `cnt_taken` output CNT_W: number of resolved taken branches.

## Operation
- **States:** IDLE, WAIT, RESOLVE (2-bit state register).
- **Accept:** in IDLE, `id_valid & id_is_branch & ~ex_flush` is an accept.
  - Latch `id_funct3`, `id_pc`, `id_imm`.
  - Go to RESOLVE if `rs1_ready & rs2_ready`; otherwise go to WAIT.
- **WAIT:** stay while either operand is not ready. Go to RESOLVE in the first cycle both are ready.
- **RESOLVE:** `cmp_c` is sampled this cycle. Always return to IDLE.
- **funct3 to `cmp_ctrl` mapping** (registered at accept; 000 outside RESOLVE):
  - 000 (BEQ) to 001; 001 (BNE) to 010.
  - 100 (BLT) to 011; 101 (BGE) to 101.
  - 110 (BLTU) to 100; 111 (BGEU) to 110.
  - 010 and 011 to 000, so the comparator returns 0.
- **Stall:** `stall_if_id` = (IDLE & accept) | WAIT. It is 0 in RESOLVE, so the branch leaves ID at the end of RESOLVE with stable operands.
- **Taken branch in RESOLVE** (`cmp_c=1` with legal funct3):
  - `redirect_valid=1` and `flush_if=1` combinationally.
  - `redirect_pc` = latched pc + latched imm, modulo 2^32.
  - `redirect_pc` reads 0 when `redirect_valid=0`.
- **Counters:** in RESOLVE with legal funct3, `cnt_branch` increments by 1, and `cnt_taken` also increments by 1 if `cmp_c`. Both wrap modulo 2^CNT_W.
- **Illegal funct3** in RESOLVE: `illegal_br=1`, not taken, no counter change.
- **`ex_flush`:** in any state, `ex_flush=1` forces IDLE at the next edge.
  - `redirect_valid`, `flush_if` and `illegal_br` are suppressed that cycle; counters are unchanged.
  - `stall_if_id` is 0 that cycle.
- **Priority:** `rst` > `ex_flush` > normal operation.
- **Non-branch instructions** in IDLE: no action; all outputs stay 0.

## Timing
- **Reset:** `rst=1` at an edge sets state IDLE, latched fields 0, `cmp_ctrl=000`, and both counters 0. `stall_if_id`, `redirect_valid`, `flush_if` and `illegal_br` are 0 during and after reset until an accept.
- **Reset mid-operation** (WAIT or RESOLVE): the branch is dropped, with no redirect and no count.
- **Latency with operands ready:** accept cycle (stall=1), then RESOLVE (redirect if taken). Minimum 2 cycles per branch; the PC is redirected at the end of RESOLVE.
- **Latency with operands not ready:** accept, then N WAIT cycles, then RESOLVE. Stall is 1 for 1+N cycles.
- **Back-to-back branches:**
  - After not-taken: the next branch enters ID after RESOLVE and is accepted in the following IDLE cycle.
  - After taken: the flush produces a bubble, so no accept occurs in the next cycle.
- **`cmp_ctrl`:** driven from a register, valid only in RESOLVE. `cmp_c` must settle within the same cycle.

## Test plan
- **BEQ taken:** x1=x2=5, funct3 000, pc 0x100, imm 0x20, operands ready.
  - Accept cycle: stall=1.
  - Next cycle: `cmp_ctrl`=001, `redirect_valid`=1, `redirect_pc`=0x120, `flush_if`=1.
  - `cnt_branch`=1, `cnt_taken`=1.
- **BLT signed vs BLTU:** a=0xFFFFFFFF, b=1.
  - BLT (100): `cmp_ctrl`=011, taken.
  - BLTU (110): `cmp_ctrl`=100, not taken, no redirect.
  - Counters end at branch=2, taken=1.
- **Load-use wait:** BNE with `rs1_ready` low for 3 cycles, then high.
  - Stall=1 for 4 cycles, then RESOLVE.
  - Taken: `redirect_pc` = 0x1000 + 0xFFFFFFF0 = 0xFF0.
- **Illegal funct3 010:** `cmp_ctrl`=000, `illegal_br` pulses in RESOLVE, no redirect, counters unchanged.
- **`ex_flush` in WAIT:** state goes to IDLE next edge, stall drops the same cycle, no redirect, counters unchanged.
  - Then reassert `rst` during RESOLVE of a taken BGE: no redirect, counters read 0.
- **Wrap:** with CNT_W=4, resolve 17 legal taken branches; `cnt_branch`=1 and `cnt_taken`=1.
